// File: rtl/reg_seq_ctrl.sv
// Command sequencer in front of the 4-entry register bank: runs LOAD/MOV/ADD/OUT
// as a multi-cycle Moore FSM and drives the bank's thermometer-coded selects.
module reg_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [1:0]       i_cmd_dst,
  input  logic [1:0]       i_cmd_src_a,
  input  logic [1:0]       i_cmd_src_b,
  input  logic [WIDTH-1:0] i_cmd_imm,
  output logic [SEL_W-1:0] o_bank_en,
  output logic [SEL_W-1:0] o_bank_out,
  output logic [WIDTH-1:0] o_bank_wdata,
  input  logic [WIDTH-1:0] i_bank_rdata,
  output logic             o_res_valid,
  output logic [WIDTH-1:0] o_res_data,
  input  logic             i_res_ready,
  output logic             o_ovf
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR, RESULT} state_t;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_MOV  = 2'd1;
  localparam logic [1:0] OP_ADD  = 2'd2;

  localparam logic [SEL_W-1:0] SEL_IDLE = '1;

  state_t           r_state;
  state_t           w_nextState;
  logic [1:0]       r_op;
  logic [1:0]       r_dst;
  logic [1:0]       r_srcA;
  logic [1:0]       r_srcB;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_resData;
  logic             r_ovf;
  logic [WIDTH:0]   w_sum;

  // Index n selects with n low ones; all-ones is reserved as the idle code.
  function automatic logic [SEL_W-1:0] selCode(input logic [1:0] idx);
    logic [SEL_W-1:0] code;
    code = '0;
    for (int k = 0; k < 3; k++) begin
      if (k < int'(idx)) code[k] = 1'b1;
    end
    return code;
  endfunction

  assign w_sum = {1'b0, r_opa} + {1'b0, i_bank_rdata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    o_cmd_ready = 1'b0;
    o_res_valid = 1'b0;
    o_bank_en   = SEL_IDLE;
    o_bank_out  = SEL_IDLE;
    case (r_state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) w_nextState = (i_cmd_op == OP_LOAD) ? WR : RD_A;
      end
      RD_A: begin
        o_bank_out = selCode(r_srcA);
        if (r_op == OP_MOV)      w_nextState = WR;
        else if (r_op == OP_ADD) w_nextState = RD_B;
        else                     w_nextState = RESULT;
      end
      RD_B: begin
        o_bank_out  = selCode(r_srcB);
        w_nextState = WR;
      end
      WR: begin
        o_bank_en   = selCode(r_dst);
        w_nextState = IDLE;
      end
      RESULT: begin
        o_res_valid = 1'b1;
        if (i_res_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Write data is loaded on the edge that enters WR, so it is settled for the whole WR cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= '0;
      r_dst     <= '0;
      r_srcA    <= '0;
      r_srcB    <= '0;
      r_opa     <= '0;
      r_wdata   <= '0;
      r_resData <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_cmd_valid) begin
            r_op   <= i_cmd_op;
            r_dst  <= i_cmd_dst;
            r_srcA <= i_cmd_src_a;
            r_srcB <= i_cmd_src_b;
            if (i_cmd_op == OP_LOAD) r_wdata <= i_cmd_imm;
          end
        end
        RD_A: begin
          r_opa <= i_bank_rdata;
          if (r_op == OP_MOV) r_wdata <= i_bank_rdata;
          if (r_op != OP_MOV && r_op != OP_ADD) r_resData <= i_bank_rdata;
        end
        RD_B: begin
          r_opa   <= w_sum[WIDTH-1:0];
          r_wdata <= w_sum[WIDTH-1:0];
          r_ovf   <= w_sum[WIDTH];
        end
        default: ;
      endcase
    end
  end

  assign o_bank_wdata = r_wdata;
  assign o_res_data   = r_resData;
  assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Self-checking bench for reg_seq_ctrl with a behavioural 4x16 register bank
// attached to its select/data buses.
module tb_reg_seq_ctrl;

  localparam int WIDTH = 16;
  localparam int SEL_W = 6;
  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_MOV  = 2'd1;
  localparam logic [1:0] OP_ADD  = 2'd2;
  localparam logic [1:0] OP_OUT  = 2'd3;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  dst;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [15:0] imm;
    int          expCycles;
    logic [15:0] expVal;
    logic        expOvf;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [1:0]       i_cmd_op;
  logic [1:0]       i_cmd_dst;
  logic [1:0]       i_cmd_src_a;
  logic [1:0]       i_cmd_src_b;
  logic [WIDTH-1:0] i_cmd_imm;
  logic [SEL_W-1:0] o_bank_en;
  logic [SEL_W-1:0] o_bank_out;
  logic [WIDTH-1:0] o_bank_wdata;
  logic [WIDTH-1:0] i_bank_rdata;
  logic             o_res_valid;
  logic [WIDTH-1:0] o_res_data;
  logic             i_res_ready;
  logic             o_ovf;

  logic [WIDTH-1:0] bank [4];
  logic             bankClear;
  int               cyc = 0;
  logic             monEn = 1'b0;
  logic             monDst = 1'b0;
  logic             prevEnBusy = 1'b0;
  int               enViolations = 0;
  logic             dstSeen = 1'b0;
  int               checkCount = 0;
  int               passCount = 0;
  vec_t             vecs [13];

  always #5 clk = ~clk;

  reg_seq_ctrl #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_dst(i_cmd_dst),
    .i_cmd_src_a(i_cmd_src_a), .i_cmd_src_b(i_cmd_src_b), .i_cmd_imm(i_cmd_imm),
    .o_bank_en(o_bank_en), .o_bank_out(o_bank_out),
    .o_bank_wdata(o_bank_wdata), .i_bank_rdata(i_bank_rdata),
    .o_res_valid(o_res_valid), .o_res_data(o_res_data),
    .i_res_ready(i_res_ready), .o_ovf(o_ovf)
  );

  function automatic int codeToIdx(input logic [SEL_W-1:0] c);
    case (c)
      6'b000000: return 0;
      6'b000001: return 1;
      6'b000011: return 2;
      6'b000111: return 3;
      default:   return -1;
    endcase
  endfunction

  // Behavioural bank: combinational read, write at the closing edge of a valid write select.
  always_comb begin
    int ri;
    ri = codeToIdx(o_bank_out);
    i_bank_rdata = 16'hDEAD;
    if (ri >= 0) i_bank_rdata = bank[ri];
  end

  always @(posedge clk) begin
    int wi;
    wi = codeToIdx(o_bank_en);
    if (bankClear) begin
      for (int i = 0; i < 4; i++) bank[i] <= '0;
    end else if (wi >= 0) begin
      bank[wi] <= o_bank_wdata;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (monEn && o_bank_en != 6'h3F && prevEnBusy) enViolations <= enViolations + 1;
    if (monDst && o_bank_en == 6'b000011) dstSeen <= 1'b1;
    prevEnBusy <= (o_bank_en != 6'h3F);
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Issues one command from a negedge and counts cycles until cmd_ready returns.
  task automatic applyStimulus(input vec_t v, output int cycles, output logic [15:0] res);
    int guard;
    guard = 0;
    res = 16'hBAD0;
    while (!o_cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    i_cmd_valid = 1'b1;
    i_cmd_op    = v.op;
    i_cmd_dst   = v.dst;
    i_cmd_src_a = v.a;
    i_cmd_src_b = v.b;
    i_cmd_imm   = v.imm;
    @(posedge clk);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    cycles = 1;
    while (!o_cmd_ready && cycles < 20) begin
      if (o_res_valid) res = o_res_data;
      @(negedge clk);
      cycles++;
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] a,
                              input logic [1:0] b, input logic [15:0] imm, input int ec,
                              input logic [15:0] ev, input logic eo);
    vec_t v;
    v.op = op; v.dst = dst; v.a = a; v.b = b; v.imm = imm;
    v.expCycles = ec; v.expVal = ev; v.expOvf = eo;
    return v;
  endfunction

  initial begin
    int          cycles;
    logic [15:0] res;
    int          acc [4];
    int          guard;
    vec_t        v;

    vecs[0]  = mk(OP_LOAD, 2'd2, 2'd0, 2'd0, 16'h1234, 2, 16'h1234, 1'b0);
    vecs[1]  = mk(OP_OUT,  2'd0, 2'd2, 2'd0, 16'h0000, 3, 16'h1234, 1'b0);
    vecs[2]  = mk(OP_LOAD, 2'd1, 2'd0, 2'd0, 16'hFFFF, 2, 16'hFFFF, 1'b0);
    vecs[3]  = mk(OP_LOAD, 2'd3, 2'd0, 2'd0, 16'h0002, 2, 16'h0002, 1'b0);
    vecs[4]  = mk(OP_ADD,  2'd0, 2'd1, 2'd3, 16'h0000, 4, 16'h0001, 1'b1);
    vecs[5]  = mk(OP_OUT,  2'd0, 2'd0, 2'd0, 16'h0000, 3, 16'h0001, 1'b1);
    vecs[6]  = mk(OP_LOAD, 2'd2, 2'd0, 2'd0, 16'h0001, 2, 16'h0001, 1'b1);
    vecs[7]  = mk(OP_ADD,  2'd2, 2'd2, 2'd2, 16'h0000, 4, 16'h0002, 1'b0);
    vecs[8]  = mk(OP_MOV,  2'd3, 2'd0, 2'd0, 16'h0000, 3, 16'h0001, 1'b0);
    vecs[9]  = mk(OP_ADD,  2'd1, 2'd1, 2'd1, 16'h0000, 4, 16'hFFFE, 1'b1);
    vecs[10] = mk(OP_MOV,  2'd0, 2'd0, 2'd0, 16'h0000, 3, 16'h0001, 1'b1);
    vecs[11] = mk(OP_ADD,  2'd3, 2'd3, 2'd0, 16'h0000, 4, 16'h0002, 1'b0);
    vecs[12] = mk(OP_OUT,  2'd0, 2'd1, 2'd0, 16'h0000, 3, 16'hFFFE, 1'b0);

    reset = 1'b1; bankClear = 1'b1; i_res_ready = 1'b1;
    i_cmd_valid = 1'b0; i_cmd_op = '0; i_cmd_dst = '0;
    i_cmd_src_a = '0; i_cmd_src_b = '0; i_cmd_imm = '0;
    #3;
    checkOutput("reset bank_en", 32'(o_bank_en), 32'h3F);
    checkOutput("reset bank_out", 32'(o_bank_out), 32'h3F);
    checkOutput("reset cmd_ready", 32'(o_cmd_ready), 32'h1);
    checkOutput("reset res_valid", 32'(o_res_valid), 32'h0);
    checkOutput("reset res_data", 32'(o_res_data), 32'h0);
    checkOutput("reset bank_wdata", 32'(o_bank_wdata), 32'h0);
    checkOutput("reset ovf", 32'(o_ovf), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; bankClear = 1'b0;
    @(negedge clk);

    $display("[TB] directed command table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], cycles, res);
      checkOutput($sformatf("vec%0d cycles", i), 32'(cycles), 32'(vecs[i].expCycles));
      checkOutput($sformatf("vec%0d ovf", i), 32'(o_ovf), 32'(vecs[i].expOvf));
      if (vecs[i].op == OP_OUT)
        checkOutput($sformatf("vec%0d res_data", i), 32'(res), 32'(vecs[i].expVal));
      else
        checkOutput($sformatf("vec%0d bank", i), 32'(bank[vecs[i].dst]), 32'(vecs[i].expVal));
    end

    $display("[TB] result stall with a held command");
    i_res_ready = 1'b0;
    i_cmd_valid = 1'b1; i_cmd_op = OP_OUT; i_cmd_src_a = 2'd1;
    @(posedge clk);
    @(negedge clk);
    i_cmd_op = OP_LOAD; i_cmd_dst = 2'd3; i_cmd_imm = 16'hABCD;
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      checkOutput($sformatf("stall%0d res_valid", s), 32'(o_res_valid), 32'h1);
      checkOutput($sformatf("stall%0d res_data", s), 32'(o_res_data), 32'hFFFE);
      checkOutput($sformatf("stall%0d cmd_ready", s), 32'(o_cmd_ready), 32'h0);
      checkOutput($sformatf("stall%0d bank_en", s), 32'(o_bank_en), 32'h3F);
      if (s < 4) @(negedge clk);
    end
    i_res_ready = 1'b1;
    @(negedge clk);
    checkOutput("release cmd_ready", 32'(o_cmd_ready), 32'h1);
    checkOutput("release res_valid", 32'(o_res_valid), 32'h0);
    @(negedge clk);
    checkOutput("held load bank_en", 32'(o_bank_en), 32'h07);
    checkOutput("held load wdata", 32'(o_bank_wdata), 32'hABCD);
    i_cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("held load bank r3", 32'(bank[3]), 32'hABCD);

    $display("[TB] back-to-back commands");
    monEn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 0)      v = mk(OP_LOAD, 2'd0, 2'd0, 2'd0, 16'h0005, 0, 16'h0, 1'b0);
      else if (c == 1) v = mk(OP_MOV,  2'd3, 2'd0, 2'd0, 16'h0000, 0, 16'h0, 1'b0);
      else             v = mk(OP_ADD,  2'd1, 2'd0, 2'd3, 16'h0000, 0, 16'h0, 1'b0);
      i_cmd_valid = 1'b1; i_cmd_op = v.op; i_cmd_dst = v.dst;
      i_cmd_src_a = v.a; i_cmd_src_b = v.b; i_cmd_imm = v.imm;
      guard = 0;
      while (!o_cmd_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      acc[c] = cyc;
      @(negedge clk);
    end
    i_cmd_valid = 1'b0;
    guard = 0;
    while (!o_cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    acc[3] = cyc;
    @(negedge clk);
    monEn = 1'b0;
    checkOutput("b2b load spacing", 32'(acc[1] - acc[0]), 32'd2);
    checkOutput("b2b mov spacing", 32'(acc[2] - acc[1]), 32'd3);
    checkOutput("b2b add spacing", 32'(acc[3] - acc[2]), 32'd4);
    checkOutput("b2b adjacent writes", 32'(enViolations), 32'd0);
    checkOutput("b2b r3", 32'(bank[3]), 32'h0005);
    checkOutput("b2b r1", 32'(bank[1]), 32'h000A);
    checkOutput("b2b ovf", 32'(o_ovf), 32'h0);

    $display("[TB] reset during RD_B");
    applyStimulus(mk(OP_LOAD, 2'd1, 2'd0, 2'd0, 16'h8000, 0, 16'h0, 1'b0), cycles, res);
    applyStimulus(mk(OP_ADD, 2'd0, 2'd1, 2'd1, 16'h0000, 0, 16'h0, 1'b0), cycles, res);
    checkOutput("pre-reset ovf", 32'(o_ovf), 32'h1);
    checkOutput("pre-reset r0", 32'(bank[0]), 32'h0000);
    i_cmd_valid = 1'b1; i_cmd_op = OP_ADD; i_cmd_dst = 2'd2;
    i_cmd_src_a = 2'd1; i_cmd_src_b = 2'd1;
    @(posedge clk);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    monDst = 1'b1;
    @(negedge clk);
    checkOutput("rd_b bank_out", 32'(o_bank_out), 32'h01);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid reset bank_en", 32'(o_bank_en), 32'h3F);
    checkOutput("mid reset bank_out", 32'(o_bank_out), 32'h3F);
    checkOutput("mid reset ovf", 32'(o_ovf), 32'h0);
    checkOutput("mid reset cmd_ready", 32'(o_cmd_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    monDst = 1'b0;
    @(negedge clk);
    checkOutput("aborted add no write code", 32'(dstSeen), 32'h0);
    checkOutput("aborted add r2 kept", 32'(bank[2]), 32'h0002);
    applyStimulus(mk(OP_LOAD, 2'd2, 2'd0, 2'd0, 16'h5A5A, 0, 16'h0, 1'b0), cycles, res);
    checkOutput("post-reset load cycles", 32'(cycles), 32'd2);
    checkOutput("post-reset load r2", 32'(bank[2]), 32'h5A5A);
    checkOutput("post-reset ovf", 32'(o_ovf), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/reg_seq_ctrl.md
Name: reg_seq_ctrl

Overview:
Command sequencer that sits directly upstream of the 4-entry, 16-bit register bank. It drives the bank's thermometer-coded write-select, read-select and write-data inputs, and reads the bank's read-data bus back. It accepts LOAD/MOV/ADD/OUT commands over a valid/ready handshake. It runs each command as a multi-cycle Moore FSM and returns OUT results over a second valid/ready handshake.

Parameters:
WIDTH, 16, data width of the bank and the result.
SEL_W, 6, width of the bank select codes.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command.
cmd_op  input  2  0=LOAD, 1=MOV, 2=ADD, 3=OUT.
cmd_dst  input  2  destination register index.
cmd_src_a  input  2  source A index (MOV/ADD/OUT).
cmd_src_b  input  2  source B index (ADD only).
cmd_imm  input  WIDTH  immediate value for LOAD.
bank_en  output  SEL_W  bank write select.
bank_out  output  SEL_W  bank read select.
bank_wdata  output  WIDTH  bank write data.
bank_rdata  input  WIDTH  bank read data (combinational from bank_out).
res_valid  output  1  OUT result available.
res_data  output  WIDTH  OUT result.
res_ready  input  1  consumer accepts the result.
ovf  output  1  carry-out of the last completed ADD.

Behaviour:
- Select code for index 0/1/2/3: 6'b000000 / 000001 / 000011 / 000111. The idle code 6'b111111 means no write (bank_en) or bus released (bank_out).
- Reset (asynchronous, takes effect immediately): state=IDLE, bank_en=bank_out=6'b111111, bank_wdata=0, res_valid=0, res_data=0, ovf=0, cmd_ready=1. Any in-flight command is dropped. No write code may appear on bank_en while reset is high.
- States: IDLE, RD_A, RD_B, WR, RESULT. bank_en and bank_out are decoded from the registered state only (Moore), so no glitches occur.
- IDLE:
  - cmd_ready=1.
  - On a rising edge with cmd_valid=1, latch op, dst, src_a, src_b and imm.
  - LOAD goes to WR. MOV, ADD and OUT go to RD_A.
  - cmd_ready=0 in every other state.
- RD_A:
  - bank_out=code(src_a) for exactly one cycle.
  - bank_rdata is captured into opa at the closing edge.
  - Next state: MOV goes to WR, ADD goes to RD_B, OUT goes to RESULT.
- RD_B:
  - bank_out=code(src_b) for one cycle.
  - At the closing edge: sum = opa + bank_rdata, computed at WIDTH+1 bits. The low WIDTH bits are captured into opa; bit WIDTH goes to ovf.
  - Next state: WR.
- WR:
  - bank_en=code(dst) for exactly one cycle.
  - bank_wdata = imm for LOAD, otherwise opa.
  - Next state: IDLE.
  - The bank latches the data at the closing edge of WR.
- RESULT:
  - res_valid=1 and res_data=opa, both held stable while res_ready=0.
  - On an edge with res_ready=1, go to IDLE and drop res_valid.
- bank_wdata holds its last value outside WR. bank_out=6'b111111 outside RD_A and RD_B.
- Throughput from accept edge to next cmd_ready=1:
  - LOAD: 2 cycles.
  - MOV: 3 cycles.
  - ADD: 4 cycles.
  - OUT: 2 cycles plus result-stall cycles, minimum 3.
- Aliasing (src_a==src_b, src==dst): legal. Reads always precede the write, so the old value is used.
- ovf changes only at the RD_B closing edge. It is sticky across LOAD, MOV and OUT.
- A command presented while cmd_ready=0 is ignored. The producer holds it until the handshake completes.

Test Plan:
1. Assert reset mid-cycle -> bank_en=bank_out=6'h3F at once, cmd_ready=1, res_valid=0, ovf=0. Release reset -> IDLE.
2. LOAD imm=16'h1234, dst=2 -> next cycle bank_en=6'b000011, bank_wdata=16'h1234 for one cycle. Then OUT src_a=2 -> bank_out=6'b000011 one cycle, then res_valid=1 and res_data=16'h1234.
3. LOAD r1=16'hFFFF, LOAD r3=16'h0002, ADD dst=0 a=1 b=3 -> r0=16'h0001, ovf=1. Then LOAD r2=1, ADD dst=2 a=2 b=2 -> r2=16'h0002, ovf=0.
4. OUT with res_ready held low 5 cycles -> res_valid and res_data stable, cmd_ready=0 throughout. res_ready=1 -> IDLE the next cycle. cmd_valid held during the stall is accepted only then.
5. Back-to-back LOAD, MOV r0->r3, ADD with cmd_valid always high -> cmd_ready pulses at 2/3/4-cycle spacing. The bank_en sequence never shows two non-idle codes in consecutive cycles.
6. Assert reset during RD_B of an ADD -> bank_en never shows code(dst), ovf=0, FSM in IDLE. A following LOAD completes normally.
